seg_hex_scan_n: RTL

- Parametrised successor to the fixed 6-digit hex display driver.
- Multiplexes NUM_DIGITS hex nibbles onto a common-segment 7-segment display.
- Features: per-digit enable, per-digit decimal point, leading-zero blanking, PWM brightness, tear-free frame-synchronous data latching.
- Sits beside the UART MCU and is fed from its debug/out ports.

---
 rtl/seg_hex_scan_n.sv | 139 +++++++++++++
 1 files changed

// File: rtl/seg_hex_scan_n.sv
// Multiplexed hex driver for a common-segment 7-segment display with per-digit enable/dp,
// leading-zero blanking, PWM brightness and shadow registers that reload only at frame start.
module seg_hex_scan_n #(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int DIM_BITS       = 3,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic [DIM_BITS-1:0]     brightness,
    input  logic                    hold,
    output logic [NUM_DIGITS-1:0]   seg_sel,
    output logic [7:0]              seg_led,
    output logic                    frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Wide enough for (2^DIM_BITS) * SCAN_DIV without overflow.
    localparam int OW = PW + DIM_BITS + 1;

    localparam logic [PW-1:0]         PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};
    localparam logic [7:0]            LED_OFF = {8{SEG_ACTIVE_LOW != 0}};

    logic [PW-1:0]           prescaler_q, prescaler_d;
    logic [IW-1:0]           index_q, index_d;
    logic [4*NUM_DIGITS-1:0] data_sh_q;
    logic [NUM_DIGITS-1:0]   dp_sh_q;
    logic [NUM_DIGITS-1:0]   en_sh_q;
    logic                    lz_sh_q;
    logic [DIM_BITS-1:0]     bri_sh_q;
    logic [NUM_DIGITS-1:0]   seg_sel_q, seg_sel_d;
    logic [7:0]              seg_led_q, seg_led_d;
    logic                    frame_tick_q;

    logic                    frame_start;
    logic [OW-1:0]           on_time;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   nib_zero;
    logic [NUM_DIGITS-1:0]   blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign frame_start = (prescaler_q == '0) && (index_q == '0);
    assign on_time     = ((OW'(bri_sh_q) + OW'(1)) * OW'(SCAN_DIV)) >> DIM_BITS;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi]      = data_sh_q[4*gi +: 4];
            assign nib_zero[gi] = (data_sh_q[4*gi +: 4] == 4'd0);
        end
    endgenerate

    // Walk from the leftmost digit down; "clear" stays set while every enabled digit above is zero.
    always_comb begin
        logic clear;
        clear = 1'b1;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (i > 0) begin
                blank[i] = lz_sh_q & nib_zero[i] & clear;
            end
            clear = clear & (~en_sh_q[i] | nib_zero[i]);
        end
    end

    always_comb begin
        prescaler_d = prescaler_q + 1'b1;
        index_d     = index_q;
        if (prescaler_q == PRE_MAX) begin
            prescaler_d = '0;
            index_d     = (index_q == IDX_MAX) ? '0 : index_q + 1'b1;
        end
    end

    always_comb begin
        logic [NUM_DIGITS-1:0] onehot;
        logic [7:0]            led_raw;
        onehot    = NUM_DIGITS'(1) << index_q;
        led_raw   = {dp_sh_q[index_q], blank[index_q] ? 7'h00 : hex_to_seg(nib[index_q])};
        seg_sel_d = SEL_OFF;
        seg_led_d = LED_OFF;
        // prescaler==0 is always dark so the previous digit's segments never ghost into this one.
        if ((prescaler_q != '0) && (OW'(prescaler_q) < on_time) && en_sh_q[index_q]) begin
            seg_sel_d = (SEL_ACTIVE_LOW != 0) ? ~onehot : onehot;
            seg_led_d = (SEG_ACTIVE_LOW != 0) ? ~led_raw : led_raw;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            prescaler_q  <= '0;
            index_q      <= '0;
            data_sh_q    <= '0;
            dp_sh_q      <= '0;
            en_sh_q      <= '0;
            lz_sh_q      <= 1'b0;
            bri_sh_q     <= '0;
            seg_sel_q    <= SEL_OFF;
            seg_led_q    <= LED_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            index_q      <= index_d;
            if (frame_start && !hold) begin
                data_sh_q <= data;
                dp_sh_q   <= dp_en;
                en_sh_q   <= digit_en;
                lz_sh_q   <= lz_blank;
                bri_sh_q  <= brightness;
            end
            seg_sel_q    <= seg_sel_d;
            seg_led_q    <= seg_led_d;
            frame_tick_q <= frame_start;
        end
    end

    assign seg_sel    = seg_sel_q;
    assign seg_led    = seg_led_q;
    assign frame_tick = frame_tick_q;

endmodule
